// File: rtl/switch_debounce.sv
// Two-channel switch debouncer feeding a 2-bit demux select, with registered
// press/release pulses, a selection-change pulse and an 8-bit change counter.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_switch_1,
  input  logic       i_switch_2,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic       o_press_1,
  output logic       o_press_2,
  output logic       o_release_1,
  output logic       o_release_2,
  output logic       o_sel_change,
  output logic [7:0] o_change_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int unsigned NCH   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [NCH-1:0]            raw_c;
  logic [NCH-1:0]            meta_q, meta_d;
  logic [NCH-1:0]            sync_q, sync_d;
  logic [NCH-1:0]            deb_q, deb_d;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]            accept_c;
  logic [NCH-1:0]            press_q, press_d;
  logic [NCH-1:0]            release_q, release_d;
  logic                      sel_change_q, sel_change_d;
  logic [7:0]                change_count_q, change_count_d;

  assign raw_c = {i_switch_2, i_switch_1};

  // Per-channel debounce: any return to the accepted level clears the count.
  always_comb begin
    meta_d   = raw_c;
    sync_d   = meta_q;
    deb_d    = deb_q;
    cnt_d    = '0;
    accept_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept_c[i] = 1'b1;
          deb_d[i]    = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    press_d        = accept_c & sync_q;
    release_d      = accept_c & ~sync_q;
    sel_change_d   = |accept_c;
    change_count_d = change_count_q + 8'(sel_change_d);
  end

  // Pulses and count load on the same edge as the debounced level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q         <= '0;
      sync_q         <= '0;
      deb_q          <= '0;
      cnt_q          <= '0;
      press_q        <= '0;
      release_q      <= '0;
      sel_change_q   <= 1'b0;
      change_count_q <= '0;
    end else begin
      meta_q         <= meta_d;
      sync_q         <= sync_d;
      deb_q          <= deb_d;
      cnt_q          <= cnt_d;
      press_q        <= press_d;
      release_q      <= release_d;
      sel_change_q   <= sel_change_d;
      change_count_q <= change_count_d;
    end
  end

  assign o_switch_1     = deb_q[0];
  assign o_switch_2     = deb_q[1];
  assign o_press_1      = press_q[0];
  assign o_press_2      = press_q[1];
  assign o_release_1    = release_q[0];
  assign o_release_2    = release_q[1];
  assign o_sel_change   = sel_change_q;
  assign o_change_count = change_count_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with DEBOUNCE_LIMIT=4: stimulus pushes
// expected pulse events, a negedge monitor pops and compares them.
module tb_switch_debounce;

  localparam int unsigned LIMIT = 4;

  logic       clk;
  logic       rst;
  logic       sw1, sw2;
  logic       o_switch_1, o_switch_2;
  logic       o_press_1, o_press_2;
  logic       o_release_1, o_release_2;
  logic       o_sel_change;
  logic [7:0] o_change_count;

  typedef struct {
    int         cyc;
    logic [1:0] sw;
    logic [1:0] press;
    logic [1:0] rel;
    logic [7:0] count;
  } evt_t;

  evt_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  logic [7:0] exp_count;

  switch_debounce #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_switch_1    (sw1),
    .i_switch_2    (sw2),
    .o_switch_1    (o_switch_1),
    .o_switch_2    (o_switch_2),
    .o_press_1     (o_press_1),
    .o_press_2     (o_press_2),
    .o_release_1   (o_release_1),
    .o_release_2   (o_release_2),
    .o_sel_change  (o_sel_change),
    .o_change_count(o_change_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with any pulse must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (o_sel_change || o_press_1 || o_press_2 || o_release_1 || o_release_2)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse sel=%b press=%b%b rel=%b%b expected no pulse (cycle %0d)",
                 o_sel_change, o_press_2, o_press_1, o_release_2, o_release_1, cyc);
      end else begin
        evt_t e;
        e = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("sel_change", 32'(o_sel_change), 32'd1);
        check("switch_lvl", 32'({o_switch_2, o_switch_1}), 32'(e.sw));
        check("press", 32'({o_press_2, o_press_1}), 32'(e.press));
        check("release", 32'({o_release_2, o_release_1}), 32'(e.rel));
        check("change_count", 32'(o_change_count), 32'(e.count));
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Drive new raw levels at a negedge and queue the accepted-change event.
  task automatic drive(input logic s2, input logic s1, input logic expect_change);
    evt_t e;
    logic [1:0] prev;
    prev = {sw2, sw1};
    sw1 = s1;
    sw2 = s2;
    if (expect_change) begin
      exp_count = exp_count + 8'd1;
      e.cyc   = cyc + int'(LIMIT) + 2;
      e.sw    = {s2, s1};
      e.press = {s2, s1} & ~prev;
      e.rel   = prev & ~{s2, s1};
      e.count = exp_count;
      sb.push_back(e);
    end
  endtask

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    exp_count = 8'd0;
    rst = 1'b1;
    sw1 = 1'b0;
    sw2 = 1'b0;
    step(3);
    check("reset_outputs", 32'({o_switch_2, o_switch_1, o_press_2, o_press_1,
                                o_release_2, o_release_1, o_sel_change}), 32'd0);
    check("reset_count", 32'(o_change_count), 32'd0);
    rst = 1'b0;
    step(2);

    // Single press with latency probes one edge before and at acceptance.
    drive(1'b0, 1'b1, 1'b1);
    step(LIMIT + 1);
    check("sw1_before_accept", 32'(o_switch_1), 32'd0);
    step(1);
    check("sw1_at_accept", 32'(o_switch_1), 32'd1);
    step(4);
    drive(1'b0, 1'b0, 1'b1);
    step(10);

    // Bounce: high for 3 samples only, counter reaches 3 then clears.
    drive(1'b0, 1'b1, 1'b0);
    step(3);
    drive(1'b0, 1'b0, 1'b0);
    step(10);
    check("bounce_sw1", 32'(o_switch_1), 32'd0);
    check("bounce_count", 32'(o_change_count), 32'(exp_count));

    // Both channels on the same edge, then independent releases.
    drive(1'b1, 1'b1, 1'b1);
    step(10);
    drive(1'b0, 1'b1, 1'b1);
    step(10);
    check("sw1_held_while_sw2_falls", 32'(o_switch_1), 32'd1);
    drive(1'b0, 1'b0, 1'b1);
    step(10);

    // Reset in mid-count (counter=2) with switch held high.
    drive(1'b0, 1'b1, 1'b0);
    step(4);
    rst = 1'b1;
    #1;
    check("midreset_outputs", 32'({o_switch_2, o_switch_1, o_press_2, o_press_1,
                                   o_release_2, o_release_1, o_sel_change}), 32'd0);
    check("midreset_count", 32'(o_change_count), 32'd0);
    step(3);
    exp_count = 8'd0;
    rst = 1'b0;
    begin
      evt_t e;
      exp_count = exp_count + 8'd1;
      e.cyc = cyc + int'(LIMIT) + 2; e.sw = 2'b01; e.press = 2'b01; e.rel = 2'b00;
      e.count = exp_count;
      sb.push_back(e);
    end
    step(LIMIT + 1);
    check("post_reset_sw1_before", 32'(o_switch_1), 32'd0);
    step(5);
    drive(1'b0, 1'b0, 1'b1);
    step(10);

    // Counter wrap: toggle switch 2 until 256 changes since reset.
    for (int t = 0; t < 254; t++) begin
      drive(~sw2, 1'b0, 1'b1);
      step(LIMIT + 3);
    end
    step(4);
    check("wrap_count", 32'(o_change_count), 32'd0);
    check("wrap_model", 32'(exp_count), 32'(o_change_count));

    // Every queued event must have been consumed by the monitor.
    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
